// File: rtl/lcd_spi_responder.sv
// PCD8544-style LCD controller slave: oversampled SPI receiver, command decoder,
// address-pointer logic and a 504 x 8 display RAM with a registered read port.
module lcd_spi_responder (
  input  logic       clock,
  input  logic       Reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       sce,
  input  logic       dc,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic [6:0] cur_x,
  output logic [2:0] cur_y,
  output logic       pd,
  output logic       v_mode,
  output logic       h_mode,
  output logic [1:0] disp_mode,
  output logic [6:0] vop,
  output logic [2:0] bias,
  output logic       cmd_err,
  output logic [7:0] abort_cnt
);

  localparam int unsigned RAM_DEPTH = 504;
  localparam logic [6:0]  X_LAST    = 7'd83;
  localparam logic [2:0]  Y_LAST    = 3'd5;

  // Synchronisers; sclk carries a third stage for rise detection.
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] dc_q;
  logic [1:0] sce_q;
  logic       sclk_rise;
  logic       mosi_s;
  logic       dc_s;
  logic       sce_s;

  // Serial front end. Seven stored bits plus the arriving bit form a full byte.
  logic [6:0] shift_q, shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dc_q, byte_dc_d;
  logic [7:0] abort_q, abort_d;

  // Controller state.
  logic [6:0] cur_x_q, cur_x_d;
  logic [2:0] cur_y_q, cur_y_d;
  logic       pd_q, pd_d;
  logic       v_mode_q, v_mode_d;
  logic       h_mode_q, h_mode_d;
  logic [1:0] disp_q, disp_d;
  logic [6:0] vop_q, vop_d;
  logic [2:0] bias_q, bias_d;
  logic       cmd_err_q, cmd_err_d;

  // Display RAM.
  logic [7:0] ram_q [0:RAM_DEPTH-1];
  logic [7:0] rd_data_q;
  logic [8:0] wr_addr;
  logic       ram_we;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign mosi_s    = mosi_q[1];
  assign dc_s      = dc_q[1];
  assign sce_s     = sce_q[1];

  assign wr_addr = 9'(cur_y_q) * 9'd84 + 9'(cur_x_q);
  assign ram_we  = byte_valid_q & byte_dc_q;

  function automatic logic [9:0] advance(input logic [6:0] x, input logic [2:0] y,
                                         input logic vert);
    logic [6:0] nx;
    logic [2:0] ny;
    nx = x;
    ny = y;
    if (!vert) begin
      if (x == X_LAST) begin
        nx = 7'd0;
        ny = (y == Y_LAST) ? 3'd0 : y + 3'd1;
      end else begin
        nx = x + 7'd1;
      end
    end else begin
      if (y == Y_LAST) begin
        ny = 3'd0;
        nx = (x == X_LAST) ? 7'd0 : x + 7'd1;
      end else begin
        ny = y + 3'd1;
      end
    end
    return {nx, ny};
  endfunction

  always_comb begin
    shift_d      = shift_q;
    bitcnt_d     = bitcnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    abort_d      = abort_q;
    if (sce_s) begin
      // Deselect: any partial byte is dropped and counted.
      shift_d  = '0;
      bitcnt_d = 3'd0;
      if (bitcnt_q != 3'd0 && abort_q != 8'hFF) begin
        abort_d = abort_q + 8'd1;
      end
    end else if (sclk_rise) begin
      shift_d  = {shift_q[5:0], mosi_s};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q, mosi_s};
        byte_dc_d    = dc_s;
      end
    end
  end

  always_comb begin
    cur_x_d   = cur_x_q;
    cur_y_d   = cur_y_q;
    pd_d      = pd_q;
    v_mode_d  = v_mode_q;
    h_mode_d  = h_mode_q;
    disp_d    = disp_q;
    vop_d     = vop_q;
    bias_d    = bias_q;
    cmd_err_d = 1'b0;
    if (byte_valid_q) begin
      if (byte_dc_q) begin
        {cur_x_d, cur_y_d} = advance(cur_x_q, cur_y_q, v_mode_q);
      end else if (byte_data_q == 8'h00) begin
        cmd_err_d = 1'b0;
      end else if (byte_data_q[7:3] == 5'b00100) begin
        {pd_d, v_mode_d, h_mode_d} = byte_data_q[2:0];
      end else if (!h_mode_q) begin
        if (byte_data_q[7:3] == 5'b00001 && !byte_data_q[1]) begin
          disp_d = {byte_data_q[2], byte_data_q[0]};
        end else if (byte_data_q[7:3] == 5'b01000 && byte_data_q[2:0] <= Y_LAST) begin
          cur_y_d = byte_data_q[2:0];
        end else if (byte_data_q[7] && byte_data_q[6:0] <= X_LAST) begin
          cur_x_d = byte_data_q[6:0];
        end else begin
          cmd_err_d = 1'b1;
        end
      end else begin
        if (byte_data_q[7:3] == 5'b00010) begin
          bias_d = byte_data_q[2:0];
        end else if (byte_data_q[7]) begin
          vop_d = byte_data_q[6:0];
        end else if (byte_data_q[7:2] == 6'b000001) begin
          cmd_err_d = 1'b0;
        end else begin
          cmd_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      sclk_q       <= '0;
      mosi_q       <= '0;
      dc_q         <= '0;
      sce_q        <= '0;
      shift_q      <= '0;
      bitcnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_dc_q    <= 1'b0;
      abort_q      <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      pd_q         <= 1'b0;
      v_mode_q     <= 1'b0;
      h_mode_q     <= 1'b0;
      disp_q       <= '0;
      vop_q        <= '0;
      bias_q       <= '0;
      cmd_err_q    <= 1'b0;
    end else begin
      sclk_q       <= {sclk_q[1:0], sclk};
      mosi_q       <= {mosi_q[0], mosi};
      dc_q         <= {dc_q[0], dc};
      sce_q        <= {sce_q[0], sce};
      shift_q      <= shift_d;
      bitcnt_q     <= bitcnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      abort_q      <= abort_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      pd_q         <= pd_d;
      v_mode_q     <= v_mode_d;
      h_mode_q     <= h_mode_d;
      disp_q       <= disp_d;
      vop_q        <= vop_d;
      bias_q       <= bias_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  // RAM contents survive reset; a same-cycle read returns the pre-write byte.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_q[wr_addr] <= byte_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      rd_data_q <= '0;
    end else if (rd_addr < 9'(RAM_DEPTH)) begin
      rd_data_q <= ram_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data    = rd_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign pd         = pd_q;
  assign v_mode     = v_mode_q;
  assign h_mode     = h_mode_q;
  assign disp_mode  = disp_q;
  assign vop        = vop_q;
  assign bias       = bias_q;
  assign cmd_err    = cmd_err_q;
  assign abort_cnt  = abort_q;

endmodule

// File: tb/tb_lcd_spi_responder.sv
// Directed and randomised bench for lcd_spi_responder against a behavioural
// model of the controller (linear/columnar RAM addressing, range-based decode).
module tb_lcd_spi_responder;

  logic       clock;
  logic       Reset;
  logic       sclk;
  logic       mosi;
  logic       sce;
  logic       dc;
  logic [8:0] rd_addr;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic [6:0] cur_x;
  logic [2:0] cur_y;
  logic       pd;
  logic       v_mode;
  logic       h_mode;
  logic [1:0] disp_mode;
  logic [6:0] vop;
  logic [2:0] bias;
  logic       cmd_err;
  logic [7:0] abort_cnt;

  lcd_spi_responder dut (
    .clock     (clock),
    .Reset     (Reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .sce       (sce),
    .dc        (dc),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .pd        (pd),
    .v_mode    (v_mode),
    .h_mode    (h_mode),
    .disp_mode (disp_mode),
    .vop       (vop),
    .bias      (bias),
    .cmd_err   (cmd_err),
    .abort_cnt (abort_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  // Behavioural model state.
  logic [7:0] ram_m [0:503];
  int         wq[$];
  int         m_x, m_y, m_abort, exp_valid, exp_err;
  logic       m_pd, m_v, m_h, m_bdc;
  logic [1:0] m_disp;
  logic [6:0] m_vop;
  logic [2:0] m_bias;
  logic [7:0] m_bd;

  // Pulse counters and read-during-write capture, written only by the monitor.
  int         seen_valid = 0;
  int         seen_err = 0;
  int         hz_state = 0;
  logic       hz_arm = 1'b0;
  logic [7:0] hz_old_obs = 8'h00;
  logic [7:0] hz_new_obs = 8'h00;

  always @(negedge clock) begin
    if (byte_valid) seen_valid <= seen_valid + 1;
    if (cmd_err) seen_err <= seen_err + 1;
    case (hz_state)
      0: if (hz_arm && byte_valid && byte_dc) hz_state <= 1;
      1: begin hz_old_obs <= rd_data; hz_state <= 2; end
      2: begin hz_new_obs <= rd_data; hz_state <= 3; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_abort = 0;
    m_pd = 0; m_v = 0; m_h = 0;
    m_disp = 2'b00; m_vop = 7'd0; m_bias = 3'd0;
    m_bd = 8'h00; m_bdc = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic d);
    int a;
    exp_valid++;
    m_bd = b;
    m_bdc = d;
    if (d) begin
      a = m_y * 84 + m_x;
      ram_m[a] = b;
      wq.push_back(a);
      if (!m_v) begin
        a = (a + 1) % 504;
        m_x = a % 84;
        m_y = a / 84;
      end else begin
        a = (m_x * 6 + m_y + 1) % 504;
        m_x = a / 6;
        m_y = a % 6;
      end
    end else if (b == 8'h00) begin
      m_bd = b;
    end else if (b >= 8'h20 && b <= 8'h27) begin
      m_pd = b[2]; m_v = b[1]; m_h = b[0];
    end else if (!m_h && (b == 8'h08 || b == 8'h09 || b == 8'h0C || b == 8'h0D)) begin
      m_disp = {b[2], b[0]};
    end else if (!m_h && b >= 8'h40 && b <= 8'h45) begin
      m_y = int'(b) - 'h40;
    end else if (!m_h && b >= 8'h80 && b <= 8'hD3) begin
      m_x = int'(b) - 'h80;
    end else if (m_h && b >= 8'h10 && b <= 8'h17) begin
      m_bias = 3'(int'(b) - 'h10);
    end else if (m_h && b >= 8'h80) begin
      m_vop = 7'(int'(b) - 'h80);
    end else if (m_h && b >= 8'h04 && b <= 8'h07) begin
      m_bd = b;
    end else begin
      exp_err++;
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input logic d);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clock);
      sclk = 1'b0; mosi = b[i]; dc = d;
      repeat ($urandom_range(3, 5)) @(negedge clock);
      sclk = 1'b1;
      repeat ($urandom_range(3, 5)) @(negedge clock);
    end
    sclk = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic check_state(input string t);
    check({t, "_x"},     32'(cur_x),      32'(m_x));
    check({t, "_y"},     32'(cur_y),      32'(m_y));
    check({t, "_pd"},    32'(pd),         32'(m_pd));
    check({t, "_v"},     32'(v_mode),     32'(m_v));
    check({t, "_h"},     32'(h_mode),     32'(m_h));
    check({t, "_disp"},  32'(disp_mode),  32'(m_disp));
    check({t, "_vop"},   32'(vop),        32'(m_vop));
    check({t, "_bias"},  32'(bias),       32'(m_bias));
    check({t, "_abort"}, 32'(abort_cnt),  32'(m_abort));
    check({t, "_nval"},  32'(seen_valid), 32'(exp_valid));
    check({t, "_nerr"},  32'(seen_err),   32'(exp_err));
    check({t, "_bd"},    32'(byte_data),  32'(m_bd));
    check({t, "_bdc"},   32'(byte_dc),    32'(m_bdc));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    sce = 1'b0;
    spi_bits(b, 8, d);
    sce = 1'b1;
    repeat (4) @(negedge clock);
    model_byte(b, d);
  endtask

  task automatic read_check(input int a, input logic [7:0] exp);
    @(negedge clock);
    rd_addr = 9'(a);
    @(negedge clock);
    check($sformatf("ram%0d", a), 32'(rd_data), 32'(exp));
  endtask

  task automatic check_zero(input string t);
    check({t, "_x"},     32'(cur_x),      0);
    check({t, "_y"},     32'(cur_y),      0);
    check({t, "_mode"},  32'({pd, v_mode, h_mode, disp_mode}), 0);
    check({t, "_vop"},   32'(vop),        0);
    check({t, "_bias"},  32'(bias),       0);
    check({t, "_bv"},    32'(byte_valid), 0);
    check({t, "_bd"},    32'({byte_dc, byte_data}), 0);
    check({t, "_err"},   32'(cmd_err),    0);
    check({t, "_abort"}, 32'(abort_cnt),  0);
    check({t, "_rd"},    32'(rd_data),    0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       rd;
    int         pick;
    Reset = 1'b1; sclk = 1'b0; mosi = 1'b0; sce = 1'b1; dc = 1'b0; rd_addr = 9'd0;
    exp_valid = 0; exp_err = 0;
    model_reset();
    repeat (5) @(negedge clock);
    check_zero("rst");
    Reset = 1'b0;
    repeat (4) @(negedge clock);

    send_byte(8'h21, 0); send_byte(8'h90, 0); send_byte(8'h20, 0); send_byte(8'h0C, 0);
    check("cmdseq_vop", 32'(vop), 32'h10);
    check("cmdseq_h", 32'(h_mode), 0);
    check("cmdseq_disp", 32'(disp_mode), 32'h2);
    check("cmdseq_nval", 32'(seen_valid), 4);
    check("cmdseq_nerr", 32'(seen_err), 0);
    check_state("cmdseq");

    send_byte(8'h42, 0); send_byte(8'h85, 0); send_byte(8'hAA, 1); send_byte(8'h55, 1);
    check("wr_x", 32'(cur_x), 7);
    check("wr_y", 32'(cur_y), 2);
    read_check(173, 8'hAA);
    read_check(174, 8'h55);
    check_state("wr");

    // Overwrite 173 while reading it in the same cycle.
    send_byte(8'h42, 0); send_byte(8'h85, 0);
    @(negedge clock);
    rd_addr = 9'd173;
    hz_arm = 1'b1;
    send_byte(8'h77, 1);
    check("rdw_state", 32'(hz_state), 3);
    check("rdw_old", 32'(hz_old_obs), 32'hAA);
    check("rdw_new", 32'(hz_new_obs), 32'h77);

    send_byte(8'hD3, 0); send_byte(8'h45, 0); send_byte(8'h20, 0); send_byte(8'h3C, 1);
    read_check(503, 8'h3C);
    check("wrapH_xy", 32'({cur_x, cur_y}), 0);
    send_byte(8'hD3, 0); send_byte(8'h45, 0); send_byte(8'h22, 0); send_byte(8'h5A, 1);
    read_check(503, 8'h5A);
    check("wrapV_xy", 32'({cur_x, cur_y}), 0);
    send_byte(8'h19, 1);
    check("vstep_xy", 32'({cur_x, cur_y}), 32'({7'd0, 3'd1}));
    check_state("wrap");

    sce = 1'b0;
    spi_bits(8'hF8, 5, 0);
    sce = 1'b1;
    repeat (4) @(negedge clock);
    m_abort++;
    send_byte(8'h80, 0);
    check("abort_cnt", 32'(abort_cnt), 1);
    check("abort_x", 32'(cur_x), 0);
    check_state("abort");

    send_byte(8'h20, 0); send_byte(8'h83, 0); send_byte(8'h42, 0);
    send_byte(8'h46, 0); send_byte(8'hD4, 0);
    check("err_xy", 32'({cur_x, cur_y}), 32'({7'd3, 3'd2}));
    send_byte(8'h21, 0); send_byte(8'h40, 0); send_byte(8'h05, 0); send_byte(8'h20, 0);
    check_state("err");

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      rb = 8'($urandom_range(0, 255));
      send_byte(rb, rd);
      check_state($sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 8; i++) begin
      pick = wq[$urandom_range(0, wq.size() - 1)];
      read_check(pick, ram_m[pick]);
    end

    for (int i = 0; i < 256; i++) begin
      sce = 1'b0;
      spi_bits(8'h80, 1, 0);
      sce = 1'b1;
      repeat (4) @(negedge clock);
      m_abort = (m_abort < 255) ? m_abort + 1 : 255;
    end
    check("abort_sat", 32'(abort_cnt), 255);

    // Reset in the middle of a byte: partial byte discarded, RAM retained.
    sce = 1'b0;
    spi_bits(8'hE0, 3, 0);
    Reset = 1'b1;
    repeat (3) @(negedge clock);
    check_zero("midrst");
    sce = 1'b1;
    Reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clock);
    check_state("postrst");
    read_check(173, ram_m[173]);
    read_check(503, ram_m[503]);
    send_byte(8'h81, 0);
    check("postrst_x", 32'(cur_x), 1);
    check_state("postrst2");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lcd_spi_responder.md
LCD_SPI_RESPONDER -- requirements
Module: lcd_spi_responder

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: sclk  in  1  SPI serial clock from LCD driver, asynchronous to clock.
REQ-004 SHALL have port: mosi  in  1  serial data, MSB first, valid at sclk rising edge.
REQ-005 SHALL have port: sce  in  1  chip enable, active low.
REQ-006 SHALL have port: dc  in  1  0 = command byte, 1 = display-data byte; sampled with bit 0.
REQ-007 SHALL have port: rd_addr  in  9  display RAM read address, Y*84+X, 0..503.
REQ-008 SHALL have port: rd_data  out  8  RAM byte at rd_addr, registered, 1-cycle latency.
REQ-009 SHALL have port: byte_valid  out  1  one-cycle pulse per completed byte.
REQ-010 SHALL have port: byte_data  out  8  last completed byte; byte_dc  out  1  its dc value.
REQ-011 SHALL have ports: cur_x  out  7  (0..83) and cur_y  out  3  (0..5), the RAM address pointer.
REQ-012 SHALL have ports: pd, v_mode, h_mode  out  1 each, the function-set bits.
REQ-013 SHALL have ports: disp_mode  out  2  {D,E}; vop  out  7; bias  out  3.
REQ-014 SHALL have ports: cmd_err  out  1  one-cycle pulse on an undecodable command; abort_cnt  out  8  saturating count of aborted bytes.

Function
REQ-015 SHALL synchronize sclk, mosi, dc and sce through identical 2-flop chains; sclk rise = sync stage 2 high while stage 3 low.
REQ-016 SHALL require sclk high and low each >= 3 clock periods; faster sclk is unsupported.
REQ-017 SHALL, on each detected sclk rise with synchronized sce low, shift the synchronized mosi into an 8-bit register LSB-side and increment a 3-bit bit counter.
REQ-018 SHALL, on the 8th bit, capture the synchronized dc, load byte_data/byte_dc and pulse byte_valid the following cycle.
REQ-019 SHALL, when synchronized sce goes high with bit counter 1..7, discard the partial byte, clear the counter and increment abort_cnt (saturating at 255); sce high with counter 0 is not an abort.
REQ-020 SHALL keep the bit counter at 0 and ignore sclk while sce is high.
REQ-021 SHALL act on a completed byte (decode/write) in the same cycle byte_valid is high.
REQ-022 SHALL decode commands: 0x00 NOP; 0x20-0x27 function set {pd,v_mode,h_mode}=bits[2:0], in any H.
REQ-023 SHALL with h_mode=0 decode: 0x08/0x09/0x0C/0x0D -> disp_mode={b2,b0}; 0x40-0x45 -> cur_y=b[2:0]; 0x80-0xD3 -> cur_x=b[6:0].
REQ-024 SHALL with h_mode=1 decode: 0x10-0x17 -> bias=b[2:0]; 0x80-0xFF -> vop=b[6:0]; 0x04-0x07 accepted, no output effect.
REQ-025 SHALL pulse cmd_err and change no state for any other command (e.g. 0x46, 0xD4 with H=0; 0x40 with H=1).
REQ-026 SHALL write each data byte to RAM[cur_y*84+cur_x] regardless of pd, then advance the pointer.
REQ-027 SHALL with v_mode=0 advance: cur_x+1; at 83 wrap to 0 and cur_y+1; cur_y at 5 wraps to 0.
REQ-028 SHALL with v_mode=1 advance: cur_y+1; at 5 wrap to 0 and cur_x+1; cur_x at 83 wraps to 0.
REQ-029 SHALL return old data when rd_addr equals the address written in the same cycle.
REQ-030 SHALL implement RAM as 504 x 8 bits.

Reset
REQ-031 SHALL, while Reset is high, clear sync chains, shift register, bit counter, byte_valid, byte_data, byte_dc, cur_x, cur_y, pd, v_mode, h_mode, disp_mode, vop, bias, cmd_err, abort_cnt and rd_data to 0.
REQ-032 SHALL NOT clear RAM contents on Reset.
REQ-033 SHALL discard any partial byte when Reset asserts mid-transfer, without counting an abort.

Verification
REQ-034 Command sequence 0x21,0x90,0x20,0x0C (dc=0) -> vop=0x10, h_mode=0, disp_mode=2'b10, four byte_valid pulses, no cmd_err.
REQ-035 0x42,0x85 then data 0xAA,0x55 (v_mode=0) -> RAM[173]=0xAA, RAM[174]=0x55, cur_x=7, cur_y=2.
REQ-036 cur_x=83, cur_y=5, v_mode=0, data 0x3C -> RAM[503]=0x3C, pointer wraps to (0,0); with v_mode=1 at (83,5) same wrap.
REQ-037 sce raised after 5 bits, then full byte 0x80 -> abort_cnt=1, cur_x=0, exactly one byte_valid.
REQ-038 With h_mode=0 send 0x46 and 0xD4 -> two cmd_err pulses, cur_x/cur_y unchanged.
REQ-039 Reset asserted mid-byte -> all outputs 0, abort_cnt=0, RAM previously written data still readable.
